// File: rtl/regfile.sv
// Integer register file: WB write port, two ID operand reads,
// and a req/ack debug port sharing the single write port.
module regfile #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk_i_RF,
    input  logic              rst_i_RF,
    input  logic [DATA_W-1:0] Wt_Data_i_RF,
    input  logic [ADDR_W-1:0] Wt_Addr_i_RF,
    input  logic              Wt_Enable_i_RF,
    input  logic              Rd1_Enable_i_RF,
    input  logic [ADDR_W-1:0] Rd1_Addr_i_RF,
    output logic [DATA_W-1:0] Rd1_Data_o_RF,
    input  logic              Rd2_Enable_i_RF,
    input  logic [ADDR_W-1:0] Rd2_Addr_i_RF,
    output logic [DATA_W-1:0] Rd2_Data_o_RF,
    input  logic              Dbg_Req_i_RF,
    input  logic              Dbg_We_i_RF,
    input  logic [ADDR_W-1:0] Dbg_Addr_i_RF,
    input  logic [DATA_W-1:0] Dbg_Wdata_i_RF,
    output logic              Dbg_Ack_o_RF,
    output logic [DATA_W-1:0] Dbg_Rdata_o_RF
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        ACK
    } dbg_state_e;

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];

    dbg_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              dbg_commit;

    // x0 reads zero; a same-cycle WB write to the index is forwarded.
    function automatic logic [DATA_W-1:0] read_rule(
        input logic              en,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (!en || a == '0) begin
            return '0;
        end else if (wen && waddr == a) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    // Combinational operand reads for the decode stage.
    always_comb begin
        Rd1_Data_o_RF = read_rule(Rd1_Enable_i_RF, Rd1_Addr_i_RF,
                                  regs_q[Rd1_Addr_i_RF], Wt_Enable_i_RF,
                                  Wt_Addr_i_RF, Wt_Data_i_RF);
        Rd2_Data_o_RF = read_rule(Rd2_Enable_i_RF, Rd2_Addr_i_RF,
                                  regs_q[Rd2_Addr_i_RF], Wt_Enable_i_RF,
                                  Wt_Addr_i_RF, Wt_Data_i_RF);
    end

    // Debug handshake FSM; debug writes wait until WB is quiet.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        dbg_commit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Dbg_Req_i_RF) begin
                    we_d    = Dbg_We_i_RF;
                    addr_d  = Dbg_Addr_i_RF;
                    wdata_d = Dbg_Wdata_i_RF;
                    state_d = Dbg_We_i_RF ? WR : RD;
                end
            end
            RD: begin
                rdata_d = read_rule(1'b1, addr_q, regs_q[addr_q],
                                    Wt_Enable_i_RF, Wt_Addr_i_RF,
                                    Wt_Data_i_RF);
                state_d = ACK;
            end
            WR: begin
                if (!Wt_Enable_i_RF) begin
                    dbg_commit = 1'b1;
                    rdata_d    = '0;
                    state_d    = ACK;
                end
            end
            ACK: begin
                if (!Dbg_Req_i_RF) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == ACK);
    end

    // Write-port arbitration; the two sources never collide.
    always_comb begin
        regs_d = regs_q;
        if (dbg_commit && addr_q != '0) begin
            regs_d[addr_q] = wdata_q;
        end
        if (Wt_Enable_i_RF && Wt_Addr_i_RF != '0) begin
            regs_d[Wt_Addr_i_RF] = Wt_Data_i_RF;
        end
        regs_d[0] = '0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i_RF) begin
        if (!rst_i_RF) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign Dbg_Ack_o_RF   = ack_q;
    assign Dbg_Rdata_o_RF = rdata_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile against a behavioural
// register-array model with directed and random steps.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        wen;
    logic        r1e, r2e;
    logic [4:0]  r1a, r2a;
    logic [31:0] r1d, r2d;
    logic        req, dwe;
    logic [4:0]  da;
    logic [31:0] dwd;
    logic        ack;
    logic [31:0] rdata;

    int compared;
    int mismatched;
    logic [31:0] mem [32];

    regfile dut (
        .clk_i_RF       (clk),
        .rst_i_RF       (rst),
        .Wt_Data_i_RF   (wd),
        .Wt_Addr_i_RF   (wa),
        .Wt_Enable_i_RF (wen),
        .Rd1_Enable_i_RF(r1e),
        .Rd1_Addr_i_RF  (r1a),
        .Rd1_Data_o_RF  (r1d),
        .Rd2_Enable_i_RF(r2e),
        .Rd2_Addr_i_RF  (r2a),
        .Rd2_Data_o_RF  (r2d),
        .Dbg_Req_i_RF   (req),
        .Dbg_We_i_RF    (dwe),
        .Dbg_Addr_i_RF  (da),
        .Dbg_Wdata_i_RF (dwd),
        .Dbg_Ack_o_RF   (ack),
        .Dbg_Rdata_o_RF (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic en,
                                           input logic [4:0] a);
        if (!en || a == 5'd0) return 32'd0;
        if (wen && wa == a) return wd;
        return mem[a];
    endfunction

    task automatic chk_reads(input string tag);
        check({tag, "_rd1"}, r1d, exp_rd(r1e, r1a));
        check({tag, "_rd2"}, r2d, exp_rd(r2e, r2a));
    endtask

    task automatic step();
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        end else if (wen && wa != 5'd0) begin
            mem[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_txn(input logic we, input logic [4:0] a,
                           input logic [31:0] d);
        int n;
        wen = 1'b0;
        req = 1'b1;
        dwe = we;
        da  = a;
        dwd = d;
        n   = 0;
        do begin
            step();
            n++;
        end while (!ack && n < 20);
        req = 1'b0;
        dwe = 1'b0;
        check("dbg_latency", n, 32'd2);
        check("dbg_ack", {31'd0, ack}, 32'd1);
        if (we) begin
            if (a != 5'd0) mem[a] = d;
            check("dbg_wr_rdata", rdata, 32'd0);
        end else begin
            check("dbg_rd_data", rdata, a == 5'd0 ? 32'd0 : mem[a]);
        end
        step();
        check("dbg_ack_fall", {31'd0, ack}, 32'd0);
        r1e = 1'b1;
        r1a = a;
        #1;
        chk_reads("dbg_after");
    endtask

    initial begin
        logic [31:0] v;
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        rst = 1'b0; wen = 1'b0; wa = '0; wd = '0;
        r1e = 1'b0; r2e = 1'b0; r1a = '0; r2a = '0;
        req = 1'b0; dwe = 1'b0; da = '0; dwd = '0;
        step();
        step();
        rst = 1'b1;

        // fill with random contents, then reset
        for (int i = 1; i < 32; i++) begin
            wen = 1'b1;
            wa  = 5'(i);
            wd  = $urandom;
            step();
        end
        wen = 1'b0;
        r1e = 1'b1; r1a = 5'd9;
        r2e = 1'b1; r2a = 5'd31;
        #1;
        chk_reads("prefill");
        rst = 1'b0;
        step();
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        wen = 1'b1; wa = 5'd5; wd = 32'h5555_AAAA;
        r1a = 5'd5; r2a = 5'd6;
        #1;
        check("rst_bypass", r1d, 32'h5555_AAAA);
        check("rst_x6", r2d, 32'd0);
        step();
        wen = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r1a = 5'(i);
            r2a = 5'(31 - i);
            #1;
            check("post_rst_rd1", r1d, 32'd0);
            check("post_rst_rd2", r2d, 32'd0);
        end

        // WB write with bypass, then storage; x0 never written
        wen = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        r1a = 5'd5;
        #1;
        check("x5_bypass", r1d, 32'hDEAD_BEEF);
        step();
        wen = 1'b0;
        #1;
        check("x5_stored", r1d, 32'hDEAD_BEEF);
        wen = 1'b1; wa = 5'd0; wd = 32'h1234;
        r2a = 5'd0;
        #1;
        check("x0_bypass", r2d, 32'd0);
        step();
        wen = 1'b0;
        #1;
        check("x0_stored", r2d, 32'd0);

        // random pipeline traffic
        for (int i = 0; i < 150; i++) begin
            wen = 1'($urandom);
            wa  = 5'($urandom);
            wd  = $urandom;
            r1e = ($urandom_range(0, 7) != 0);
            r2e = ($urandom_range(0, 7) != 0);
            r1a = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            r2a = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            #1;
            chk_reads("rand");
            step();
        end
        wen = 1'b0;

        // debug write x7 stalled by three WB writes
        req = 1'b1; dwe = 1'b1; da = 5'd7; dwd = 32'hA5A5_A5A5;
        step();
        wen = 1'b1; wa = 5'd9; wd = $urandom;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wr_stall_ack", {31'd0, ack}, 32'd0);
        end
        wen = 1'b0;
        step();
        mem[7] = 32'hA5A5_A5A5;
        check("wr_ack", {31'd0, ack}, 32'd1);
        check("wr_rdata", rdata, 32'd0);
        req = 1'b0; dwe = 1'b0;
        r1e = 1'b1; r1a = 5'd7;
        r2e = 1'b1; r2a = 5'd9;
        #1;
        check("x7_dbg", r1d, 32'hA5A5_A5A5);
        chk_reads("after_stall");
        step();
        check("wr_ack_fall", {31'd0, ack}, 32'd0);

        // debug read x3 with WB bypass in the RD cycle
        wen = 1'b1; wa = 5'd3; wd = 32'h11;
        step();
        wen = 1'b0;
        req = 1'b1; dwe = 1'b0; da = 5'd3;
        step();
        check("rd_early_ack", {31'd0, ack}, 32'd0);
        wen = 1'b1; wa = 5'd3; wd = 32'h22;
        step();
        check("rd_ack", {31'd0, ack}, 32'd1);
        check("rd_bypass", rdata, 32'h22);
        wd = 32'h33;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_hold_ack", {31'd0, ack}, 32'd1);
            check("rd_no_retrig", rdata, 32'h22);
        end
        wen = 1'b0;
        req = 1'b0;
        step();
        check("rd_ack_fall", {31'd0, ack}, 32'd0);
        check("rd_rdata_hold", rdata, 32'h22);
        r1a = 5'd3;
        #1;
        chk_reads("x3");

        // reset during a stalled debug write
        req = 1'b1; dwe = 1'b1; da = 5'd12; dwd = 32'hCAFE_F00D;
        step();
        wen = 1'b1; wa = 5'd13; wd = $urandom;
        step();
        check("stall2_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0; wen = 1'b0; req = 1'b0; dwe = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_ack", {31'd0, ack}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        step();
        r1a = 5'd12; r2a = 5'd13;
        #1;
        check("midrst_x12", r1d, 32'd0);
        chk_reads("midrst");
        dbg_txn(1'b0, 5'd12, 32'd0);

        // read enable low on nonzero data
        v = $urandom | 32'd1;
        wen = 1'b1; wa = 5'd20; wd = v;
        step();
        wen = 1'b0;
        r1e = 1'b0; r1a = 5'd20;
        r2e = 1'b0; r2a = 5'd20;
        #1;
        check("rd1_disabled", r1d, 32'd0);
        check("rd2_disabled", r2d, 32'd0);
        r1e = 1'b1;
        #1;
        check("rd1_enabled", r1d, v);

        // random debug transactions between WB bursts
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 3; j++) begin
                wen = 1'($urandom);
                wa  = 5'($urandom);
                wd  = $urandom;
                step();
            end
            dbg_txn(1'($urandom), 5'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
